// File: rtl/target_pkg.sv
// rtl/target_pkg.sv - shared widths, target record, FSM states and age helper for target_stream
//
// Purpose: definitions shared by target_stream and target_pick.
// Ports:   none (package).

package target_pkg;

    localparam int NUM_TARGETS_DEF   = 4;
    localparam int SCREEN_WIDTH_DEF  = 1280;
    localparam int SCREEN_HEIGHT_DEF = 720;

    localparam int XW    = $clog2(SCREEN_WIDTH_DEF) + 1;
    localparam int YW    = $clog2(SCREEN_HEIGHT_DEF) + 1;
    localparam int IW    = $clog2(NUM_TARGETS_DEF);
    localparam int AGE_W = 4;

    localparam logic [AGE_W-1:0] AGE_MAX = 4'd15;

    typedef struct packed {
        logic [XW-1:0]    x;
        logic [YW-1:0]    y;
        logic [YW-1:0]    d;
        logic [AGE_W-1:0] age;
    } target_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_e;

    // Saturating persistence age: a slot that vanishes restarts from zero.
    function automatic logic [AGE_W-1:0] age_next(input logic [AGE_W-1:0] age,
                                                  input logic             present);
        logic [AGE_W-1:0] res;
        if (!present) begin
            res = '0;
        end else if (age == AGE_MAX) begin
            res = AGE_MAX;
        end else begin
            res = age + 4'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/target_pick.sv
// rtl/target_pick.sv - lowest-set-bit priority encoder over the eligible-slot mask
//
// Purpose: selects the next slot to stream.
// Ports:
//   mask_i  in   N   eligible slots
//   idx_o   out  IW  index of the lowest set bit (0 when mask is empty)
//   any_o   out  1   at least one bit set
//   one_o   out  1   exactly one bit set

module target_pick
    import target_pkg::*;
#(
    parameter  int N      = 4,
    localparam int PICK_W = $clog2(N)
) (
    input  logic [N-1:0]      mask_i,
    output logic [PICK_W-1:0] idx_o,
    output logic              any_o,
    output logic              one_o
);

    always_comb begin
        idx_o = '0;
        // Scan downwards so the lowest set bit is the last one written.
        for (int i = N - 1; i >= 0; i--) begin
            if (mask_i[i]) begin
                idx_o = PICK_W'(i);
            end
        end
    end

    assign any_o = |mask_i;
    // Clearing the lowest set bit leaves nothing exactly when one bit was set.
    assign one_o = any_o && ((mask_i & (mask_i - N'(1))) == '0);

endmodule

// File: rtl/target_stream.sv
// rtl/target_stream.sv - per-frame snapshot of detector slots streamed as persistent targets
//
// Purpose: on each accepted frame_end_in, update per-slot ages, snapshot slot
// coordinates, then stream every slot that has persisted MIN_FRAMES frames,
// one beat per valid/ready handshake, followed by a frame_done_out pulse.
// Ports:
//   clk_in, rst_n_in            clock, asynchronous active-low reset
//   frame_end_in                end-of-frame pulse
//   xcount_in/ycount_in/diameter_in/valid_in   per-slot detector results
//   tgt_valid_out/tgt_ready_in  beat handshake
//   tgt_id_out, tgt_x_out, tgt_y_out, tgt_d_out, tgt_age_out, tgt_last_out  beat fields
//   frame_done_out              one-cycle pulse after each frame's stream
//   overrun_count_out           saturating count of frame ends dropped mid-stream

module target_stream
    import target_pkg::*;
#(
    parameter  int NUM_TARGETS   = 4,
    parameter  int SCREEN_WIDTH  = 1280,
    parameter  int SCREEN_HEIGHT = 720,
    parameter  int MIN_FRAMES    = 2,
    localparam int TXW           = $clog2(SCREEN_WIDTH) + 1,
    localparam int TYW           = $clog2(SCREEN_HEIGHT) + 1,
    localparam int TIW           = $clog2(NUM_TARGETS)
) (
    input  logic                             clk_in,
    input  logic                             rst_n_in,
    input  logic                             frame_end_in,
    input  logic [NUM_TARGETS-1:0][TXW-1:0]  xcount_in,
    input  logic [NUM_TARGETS-1:0][TYW-1:0]  ycount_in,
    input  logic [NUM_TARGETS-1:0][TYW-1:0]  diameter_in,
    input  logic [NUM_TARGETS-1:0]           valid_in,
    output logic                             tgt_valid_out,
    input  logic                             tgt_ready_in,
    output logic [TIW-1:0]                   tgt_id_out,
    output logic [TXW-1:0]                   tgt_x_out,
    output logic [TYW-1:0]                   tgt_y_out,
    output logic [TYW-1:0]                   tgt_d_out,
    output logic [AGE_W-1:0]                 tgt_age_out,
    output logic                             tgt_last_out,
    output logic                             frame_done_out,
    output logic [7:0]                       overrun_count_out
);

    localparam logic [AGE_W-1:0]       MIN_AGE = AGE_W'(MIN_FRAMES);
    localparam logic [NUM_TARGETS-1:0] ONE_HOT = NUM_TARGETS'(1);

    state_e                              state_q, state_d;
    logic [NUM_TARGETS-1:0][AGE_W-1:0]   age_q, age_new;
    logic [NUM_TARGETS-1:0][TXW-1:0]     x_q;
    logic [NUM_TARGETS-1:0][TYW-1:0]     y_q;
    logic [NUM_TARGETS-1:0][TYW-1:0]     d_q;
    logic [NUM_TARGETS-1:0]              elig_q, elig_d, elig_new;
    logic [7:0]                          ovr_q, ovr_d;

    logic [TIW-1:0] pick_idx;
    logic           pick_any;
    logic           pick_one;
    logic           accept;
    logic           fire;

    target_pick #(
        .N (NUM_TARGETS)
    ) u_pick (
        .mask_i (elig_q),
        .idx_o  (pick_idx),
        .any_o  (pick_any),
        .one_o  (pick_one)
    );

    // A frame end is only honoured while no stream is in flight.
    assign accept = frame_end_in && (state_q != SEND);
    assign fire   = tgt_valid_out && tgt_ready_in;

    always_comb begin
        age_new  = '0;
        elig_new = '0;
        for (int i = 0; i < NUM_TARGETS; i++) begin
            age_new[i]  = age_next(age_q[i], valid_in[i]);
            elig_new[i] = valid_in[i] && (age_new[i] >= MIN_AGE);
        end
    end

    always_comb begin
        state_d = state_q;
        elig_d  = elig_q;
        ovr_d   = ovr_q;
        case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    elig_d  = elig_new;
                    state_d = (|elig_new) ? SEND : DONE;
                end else begin
                    state_d = IDLE;
                end
            end
            SEND: begin
                if (fire) begin
                    elig_d = elig_q & ~(ONE_HOT << pick_idx);
                    if (pick_one) begin
                        state_d = DONE;
                    end
                end
                if (frame_end_in && (ovr_q != 8'hFF)) begin
                    ovr_d = ovr_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= IDLE;
            elig_q  <= '0;
            ovr_q   <= '0;
        end else begin
            state_q <= state_d;
            elig_q  <= elig_d;
            ovr_q   <= ovr_d;
        end
    end

    // The age register doubles as the snapshot age: both change only on accept.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            age_q <= '0;
            x_q   <= '0;
            y_q   <= '0;
            d_q   <= '0;
        end else if (accept) begin
            age_q <= age_new;
            x_q   <= xcount_in;
            y_q   <= ycount_in;
            d_q   <= diameter_in;
        end
    end

    // Beat fields come from registers only; zeroed between beats for a quiet bus.
    assign tgt_valid_out     = (state_q == SEND) && pick_any;
    assign tgt_id_out        = tgt_valid_out ? pick_idx        : '0;
    assign tgt_x_out         = tgt_valid_out ? x_q[pick_idx]   : '0;
    assign tgt_y_out         = tgt_valid_out ? y_q[pick_idx]   : '0;
    assign tgt_d_out         = tgt_valid_out ? d_q[pick_idx]   : '0;
    assign tgt_age_out       = tgt_valid_out ? age_q[pick_idx] : '0;
    assign tgt_last_out      = tgt_valid_out && pick_one;
    assign frame_done_out    = (state_q == DONE);
    assign overrun_count_out = ovr_q;

endmodule

// File: tb/tb_target_stream.sv
// tb/tb_target_stream.sv - scoreboard bench for target_stream

module tb_target_stream;

    localparam int N  = 4;
    localparam int XW = 12;
    localparam int YW = 11;
    localparam int IW = 2;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   frame_end = 1'b0;
    logic [N-1:0][XW-1:0]   xc = '0;
    logic [N-1:0][YW-1:0]   yc = '0;
    logic [N-1:0][YW-1:0]   dc = '0;
    logic [N-1:0]           vin = '0;
    logic                   tgt_ready = 1'b0;
    logic                   tgt_valid;
    logic [IW-1:0]          tgt_id;
    logic [XW-1:0]          tgt_x;
    logic [YW-1:0]          tgt_y;
    logic [YW-1:0]          tgt_d;
    logic [3:0]             tgt_age;
    logic                   tgt_last;
    logic                   frame_done;
    logic [7:0]             overrun;

    target_stream #(
        .NUM_TARGETS   (N),
        .SCREEN_WIDTH  (1280),
        .SCREEN_HEIGHT (720),
        .MIN_FRAMES    (2)
    ) dut (
        .clk_in            (clk),
        .rst_n_in          (rst_n),
        .frame_end_in      (frame_end),
        .xcount_in         (xc),
        .ycount_in         (yc),
        .diameter_in       (dc),
        .valid_in          (vin),
        .tgt_valid_out     (tgt_valid),
        .tgt_ready_in      (tgt_ready),
        .tgt_id_out        (tgt_id),
        .tgt_x_out         (tgt_x),
        .tgt_y_out         (tgt_y),
        .tgt_d_out         (tgt_d),
        .tgt_age_out       (tgt_age),
        .tgt_last_out      (tgt_last),
        .frame_done_out    (frame_done),
        .overrun_count_out (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit is_done;
        int id;
        int x;
        int y;
        int d;
        int age;
        bit last;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    // Ready generator: mode 0 follows ready_const, mode 1 plays 1,0,0 repeating.
    bit ready_mode  = 1'b0;
    bit ready_const = 1'b0;
    int ready_ph    = 0;

    always @(posedge clk) begin
        #2;
        if (ready_mode) begin
            tgt_ready = (ready_ph == 0);
            ready_ph  = (ready_ph == 2) ? 0 : ready_ph + 1;
        end else begin
            tgt_ready = ready_const;
        end
    end

    // Monitor: every cycle a beat is presented it must match the queue head;
    // it is popped only when accepted, so held beats are re-checked each cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (tgt_valid) begin
                checks++;
                if (sb.size() == 0 || sb[0].is_done) begin
                    errors++;
                    $display("FAIL beat_unexpected: got id=%0d x=%0d y=%0d d=%0d age=%0d, no beat expected",
                             tgt_id, tgt_x, tgt_y, tgt_d, tgt_age);
                end else if (tgt_id != sb[0].id || tgt_x != sb[0].x || tgt_y != sb[0].y ||
                             tgt_d != sb[0].d || tgt_age != sb[0].age || tgt_last != sb[0].last) begin
                    errors++;
                    $display("FAIL beat: got id=%0d x=%0d y=%0d d=%0d age=%0d last=%0d, expected id=%0d x=%0d y=%0d d=%0d age=%0d last=%0d",
                             tgt_id, tgt_x, tgt_y, tgt_d, tgt_age, tgt_last,
                             sb[0].id, sb[0].x, sb[0].y, sb[0].d, sb[0].age, sb[0].last);
                    if (tgt_ready) void'(sb.pop_front());
                end else if (tgt_ready) begin
                    void'(sb.pop_front());
                end
            end
            if (frame_done) begin
                checks++;
                if (sb.size() == 0 || !sb[0].is_done) begin
                    errors++;
                    $display("FAIL frame_done_early: got frame_done=1, expected %0d more beats first", sb.size());
                end else begin
                    void'(sb.pop_front());
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int sx(input int i); return 100 + i * 300; endfunction
    function automatic int sy(input int i); return 50 + i * 200;  endfunction
    function automatic int sd(input int i); return 10 + i * 5;    endfunction

    task automatic push_beat(input int id, input int x, input int y, input int d,
                             input int age, input bit last);
        exp_t e;
        e.is_done = 1'b0; e.id = id; e.x = x; e.y = y; e.d = d; e.age = age; e.last = last;
        sb.push_back(e);
    endtask

    task automatic push_done();
        exp_t e;
        e.is_done = 1'b1; e.id = 0; e.x = 0; e.y = 0; e.d = 0; e.age = 0; e.last = 1'b0;
        sb.push_back(e);
    endtask

    task automatic load_table(input logic [N-1:0] mask);
        for (int i = 0; i < N; i++) begin
            xc[i] = XW'(sx(i));
            yc[i] = YW'(sy(i));
            dc[i] = YW'(sd(i));
        end
        vin = mask;
    endtask

    task automatic load_t1(input logic [N-1:0] mask);
        xc = '0; yc = '0; dc = '0;
        xc[2] = 12'd640; yc[2] = 11'd360; dc[2] = 11'd40;
        vin = mask;
    endtask

    // Pulse frame_end for one edge, then trash coordinates to prove they were snapshotted.
    task automatic pulse();
        @(posedge clk); #1;
        frame_end = 1'b1;
        @(posedge clk); #1;
        frame_end = 1'b0;
        for (int i = 0; i < N; i++) begin
            xc[i] = '1; yc[i] = '1; dc[i] = '1;
        end
    endtask

    // Cycle offset (1 = cycle right after the accepting edge) at which frame_done appears.
    task automatic wait_done(output int n);
        n = 1;
        while (!frame_done && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        if (!frame_done) begin
            errors++;
            checks++;
            $display("FAIL done_timeout: got no frame_done after %0d cycles, expected one", n);
        end
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        frame_end = 1'b0;
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"},   tgt_valid,  0);
        chk({tag, "_done"},    frame_done, 0);
        chk({tag, "_id"},      tgt_id,     0);
        chk({tag, "_x"},       tgt_x,      0);
        chk({tag, "_age"},     tgt_age,    0);
        chk({tag, "_last"},    tgt_last,   0);
        chk({tag, "_overrun"}, overrun,    0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        int n;

        // Reset state
        #3;
        chk_all_zero("reset");
        apply_reset();
        ready_const = 1'b1;

        // Single slot persisting three frames
        push_done();
        load_t1(4'b0100); pulse(); wait_done(n); chk("t1_f1_latency", n, 1);
        push_beat(2, 640, 360, 40, 2, 1'b1); push_done();
        load_t1(4'b0100); pulse(); wait_done(n); chk("t1_f2_latency", n, 2);
        push_beat(2, 640, 360, 40, 3, 1'b1); push_done();
        load_t1(4'b0100); pulse(); wait_done(n); chk("t1_f3_latency", n, 2);

        // All slots, ready high: back-to-back beats
        apply_reset();
        push_done();
        load_table(4'hF); pulse(); wait_done(n); chk("t2_f1_latency", n, 1);
        for (int i = 0; i < N; i++) push_beat(i, sx(i), sy(i), sd(i), 2, i == N - 1);
        push_done();
        load_table(4'hF); pulse(); wait_done(n); chk("t2_f2_latency", n, 5);

        // All slots, ready toggling: beats held while stalled
        apply_reset();
        push_done();
        load_table(4'hF); pulse(); wait_done(n);
        ready_mode = 1'b1;
        for (int i = 0; i < N; i++) push_beat(i, sx(i), sy(i), sd(i), 2, i == N - 1);
        push_done();
        load_table(4'hF); pulse(); wait_done(n);
        ready_mode = 1'b0;

        // Dropped frame ends during a stalled stream
        apply_reset();
        push_done();
        load_table(4'hF); pulse(); wait_done(n);
        ready_const = 1'b0;
        @(posedge clk); #3;
        for (int i = 0; i < N; i++) push_beat(i, sx(i), sy(i), sd(i), 2, i == N - 1);
        push_done();
        load_table(4'hF); pulse();
        for (int k = 0; k < 2; k++) begin
            vin = '0;
            @(posedge clk); #1; frame_end = 1'b1;
            @(posedge clk); #1; frame_end = 1'b0;
        end
        chk("t4_overrun", overrun, 2);
        chk("t4_still_valid", tgt_valid, 1);
        chk("t4_held_id", tgt_id, 0);
        ready_const = 1'b1;
        wait_done(n);
        for (int i = 0; i < N; i++) push_beat(i, sx(i), sy(i), sd(i), 3, i == N - 1);
        push_done();
        load_table(4'hF); pulse(); wait_done(n); chk("t4_f3_latency", n, 5);
        chk("t4_overrun_after", overrun, 2);

        // Age saturation, drop-out and re-qualification on slot 1
        apply_reset();
        for (int k = 1; k <= 16; k++) begin
            if (k >= 2) push_beat(1, sx(1), sy(1), sd(1), (k > 15) ? 15 : k, 1'b1);
            push_done();
            load_table(4'b0010); pulse(); wait_done(n);
        end
        push_done();
        load_table(4'b0000); pulse(); wait_done(n); chk("t5_gone_latency", n, 1);
        push_done();
        load_table(4'b0010); pulse(); wait_done(n); chk("t5_back1_latency", n, 1);
        push_beat(1, sx(1), sy(1), sd(1), 2, 1'b1); push_done();
        load_table(4'b0010); pulse(); wait_done(n); chk("t5_back2_latency", n, 2);

        // Reset in the middle of a stalled stream
        apply_reset();
        push_done();
        load_table(4'hF); pulse(); wait_done(n);
        ready_const = 1'b0;
        @(posedge clk); #3;
        for (int i = 0; i < N; i++) push_beat(i, sx(i), sy(i), sd(i), 2, i == N - 1);
        push_done();
        load_table(4'hF); pulse();
        @(posedge clk); #1; frame_end = 1'b1;
        @(posedge clk); #1; frame_end = 1'b0;
        chk("t6_overrun_pre", overrun, 1);
        chk("t6_valid_pre", tgt_valid, 1);
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk_all_zero("t6_mid_reset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        push_done();
        load_table(4'hF); pulse(); wait_done(n); chk("t6_post_latency", n, 1);

        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("sb_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/target_stream.md
# target_stream

Frame-level consumer of the marker detector's per-slot target arrays. On each end-of-frame pulse it snapshots all target slots and updates a per-slot persistence age. It then streams the slots that have persisted long enough, one per valid/ready handshake, to the downstream pose/overlay logic. A frame-done pulse follows each frame's stream. End-of-frame pulses that arrive while a stream is in progress are dropped and counted.

## Interface
- NUM_TARGETS, 4, number of detector slots (power of two, ≥2)
- SCREEN_WIDTH, 1280, active pixels per line
- SCREEN_HEIGHT, 720, active lines per frame
- MIN_FRAMES, 2, consecutive valid frames (1..15) before a slot is emitted
- Derived widths: XW = $clog2(SCREEN_WIDTH)+1, YW = $clog2(SCREEN_HEIGHT)+1, IW = $clog2(NUM_TARGETS).

Ports:
- clk_in  in  1  pixel clock; one clock, all state on rising edge
- rst_n_in  in  1  reset, asynchronous, active-low
- frame_end_in  in  1  single-cycle pulse after the last active line
- xcount_in  in  [XW-1:0] × NUM_TARGETS  slot centre x
- ycount_in  in  [YW-1:0] × NUM_TARGETS  slot centre y
- diameter_in  in  [YW-1:0] × NUM_TARGETS  slot diameter
- valid_in  in  1 × NUM_TARGETS  slot holds a target this frame
- tgt_valid_out  out  1  output beat present
- tgt_ready_in  in  1  downstream accepts the beat
- tgt_id_out  out  IW  slot index of the beat
- tgt_x_out / tgt_y_out / tgt_d_out  out  XW / YW / YW  snapshotted coordinates
- tgt_age_out  out  4  slot age at snapshot
- tgt_last_out  out  1  no further eligible slot follows in this frame
- frame_done_out  out  1  one-cycle pulse, frame stream complete
- overrun_count_out  out  8  saturating count of dropped frame_end_in pulses

## Operation
- Per-slot age is 4-bit and saturating.
- On an accepted frame_end_in, each slot's age is updated:
  - valid_in[i]=1: age ← min(age+1, 15).
  - valid_in[i]=0: age ← 0.
- At the same edge, x/y/d and the updated age are snapshotted. The eligible mask is set: elig[i] = valid_in[i] && new_age ≥ MIN_FRAMES.
- State machine:
  - IDLE: on frame_end_in, snapshot. Go to SEND if elig≠0, else DONE.
  - SEND: present the lowest-index set bit of elig.
    - On tgt_valid_out && tgt_ready_in, clear that bit.
    - If the cleared bit was the last set bit, go to DONE; else stay in SEND and present the next set bit the following cycle.
  - DONE: frame_done_out=1 for this single cycle.
    - frame_end_in here is accepted exactly as in IDLE.
    - Otherwise go to IDLE.
- tgt_last_out = 1 when exactly one elig bit remains.
- Beat fields are held stable while tgt_valid_out=1 and tgt_ready_in=0. tgt_valid_out never drops before a handshake.
- frame_end_in in SEND: ignored. Ages and snapshot are not updated. overrun_count_out increments, saturating at 255.
- Inputs are sampled only on accepted frame_end_in cycles. Changes at other times have no effect.

## Timing
- Reset (rst_n_in low, any time including mid-stream):
  - State returns to IDLE.
  - All ages, snapshots, elig and overrun_count_out are cleared.
  - All outputs are 0.
  - The next frame starts from age 0.
- frame_end_in accepted at edge t:
  - If elig≠0, the first beat is valid in cycle t+1.
  - If elig=0, frame_done_out is high in cycle t+1.
- With ready held high, beats occupy consecutive cycles. k eligible slots give beats in t+1..t+k and frame_done_out in t+k+1.
- There is no combinational path from tgt_ready_in to tgt_valid_out or the beat fields; these are driven from registers or state only.
- MIN_FRAMES=1 makes a slot eligible in the same frame it first appears.

## Structure
- Shared package target_pkg holds:
  - width localparams XW, YW, IW.
  - a typedef target_t with fields x, y, d, age.
  - the state enum {IDLE, SEND, DONE}.
- Sub-module target_pick: combinational lowest-set-bit priority encoder over elig. It outputs the index, an any-set flag and a one-remaining flag.
- Top level holds the age counters, snapshot registers, FSM and overrun counter.

## Test plan
- Slot 2 valid with (640,360,40) for 3 frames, MIN_FRAMES=2, ready high → frame 1: no beat, frame_done at t+1. Frames 2 and 3: one beat, id=2, x=640, y=360, d=40, last=1, with age 2 then age 3.
- All 4 slots valid for 2 frames, ready high → frame 2 gives ids 0,1,2,3 in cycles t+1..t+4, last only on id 3, frame_done at t+5.
- Same as above with ready toggling 1,0,0,1,… → each beat is held unchanged while ready=0. No beat is lost or duplicated.
- frame_end_in pulsed twice during SEND, ready low → overrun_count_out=2. Ages are unchanged by the dropped pulses. The stream resumes normally when ready rises.
- Slot 1 valid for 16 frames, then invalid for 1 frame, then valid again → age saturates at 15, resets to 0, and is not emitted again until the second valid frame after.
- rst_n_in asserted mid-SEND → all outputs 0 immediately. After release, the first frame emits nothing (MIN_FRAMES=2).
